// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one BRAM port with read-latency tracking and per-requester
// response FIFOs. Define BRAM_ARB_FIXED_PRIO_EN for fixed R0 priority instead of round-robin.
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPELINED  = 0,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int unsigned L  = 1 + PIPELINED;
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH + L + 1);

  logic [1:0] req_valid, req_we, rsp_ready;
  logic [1:0] credit, elig, grant, issue, push, pop;

  logic [CW-1:0]         cnt_q  [2];
  logic [CW-1:0]         infl_q [2];
  logic [PW-1:0]         wptr_q [2];
  logic [PW-1:0]         rptr_q [2];
  logic [DATA_WIDTH-1:0] mem_q  [2][RSP_DEPTH];

  logic [L-1:0] tag_v_q, tag_v_d;
  logic [L-1:0] tag_id_q, tag_id_d;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A read reserves its FIFO slot at issue, so a full FIFO can never be overrun.
  always_comb begin
    credit = '0;
    elig   = '0;
    pop    = '0;
    for (int i = 0; i < 2; i++) begin
      credit[i] = (cnt_q[i] + infl_q[i]) < CW'(RSP_DEPTH);
      elig[i]   = req_valid[i] & (req_we[i] | credit[i]);
      pop[i]    = (cnt_q[i] != '0) & rsp_ready[i];
    end
  end

`ifdef BRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    grant[0] = rst_n & elig[0];
    grant[1] = rst_n & elig[1] & ~elig[0];
  end
`else
  logic last_grant_q;

  always_comb begin
    grant    = '0;
    grant[0] = rst_n & elig[0] & (~elig[1] | last_grant_q);
    grant[1] = rst_n & elig[1] & (~elig[0] | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (grant[0]) begin
      last_grant_q <= 1'b0;
    end else if (grant[1]) begin
      last_grant_q <= 1'b1;
    end
  end
`endif

  assign issue = grant & ~req_we;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign bram_en    = |grant;
  assign bram_we    = grant[1] ? req1_we   : (grant[0] & req0_we);
  assign bram_addr  = grant[1] ? req1_addr : req0_addr;
  assign bram_di    = grant[1] ? req1_data : req0_data;

  // Tag pipe mirrors the BRAM read latency; the last stage lines up with bram_do.
  if (L == 1) begin : g_tag_l1
    assign tag_v_d  = |issue;
    assign tag_id_d = issue[1];
  end else begin : g_tag_ln
    assign tag_v_d  = {tag_v_q[L-2:0], |issue};
    assign tag_id_d = {tag_id_q[L-2:0], issue[1]};
  end

  assign push[0] = tag_v_q[L-1] & ~tag_id_q[L-1];
  assign push[1] = tag_v_q[L-1] & tag_id_q[L-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= '0;
        infl_q[i] <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        infl_q[i] <= infl_q[i] + CW'(issue[i]) - CW'(push[i]);
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= bram_do;
    end
  end

  assign rsp0_valid = cnt_q[0] != '0;
  assign rsp1_valid = cnt_q[1] != '0;
  assign rsp0_data  = mem_q[0][rptr_q[0]];
  assign rsp1_data  = mem_q[1][rptr_q[1]];

endmodule
